// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS opcode/funct constants, ALU encodings and control bundle
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_ctrl_t;

  typedef struct packed {
    logic      reg_write;
    logic      mem_to_reg;
    logic      mem_write;
    logic      branch;
    logic      alu_src;
    logic      reg_dst;
    alu_ctrl_t alu_control;
  } ctrl_t;

  // Unrecognised opcodes decode to an all-zero bundle, which execute treats as a bubble.
  function automatic ctrl_t decode_ctrl(input logic [5:0] opcode, input logic [5:0] funct);
    ctrl_t c;
    c = '0;
    case (opcode)
      OP_RTYPE: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
        case (funct)
          FN_ADD:  c.alu_control = ALU_ADD;
          FN_SUB:  c.alu_control = ALU_SUB;
          FN_AND:  c.alu_control = ALU_AND;
          FN_OR:   c.alu_control = ALU_OR;
          FN_SLT:  c.alu_control = ALU_SLT;
          default: begin
            c.alu_control = ALU_ADD;
            c.reg_write   = 1'b0;
          end
        endcase
      end
      OP_LW: begin
        c.reg_write   = 1'b1;
        c.alu_src     = 1'b1;
        c.mem_to_reg  = 1'b1;
        c.alu_control = ALU_ADD;
      end
      OP_SW: begin
        c.mem_write   = 1'b1;
        c.alu_src     = 1'b1;
        c.alu_control = ALU_ADD;
      end
      OP_BEQ: begin
        c.branch      = 1'b1;
        c.alu_control = ALU_SUB;
      end
      OP_ADDI: begin
        c.reg_write   = 1'b1;
        c.alu_src     = 1'b1;
        c.alu_control = ALU_ADD;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/register_file.sv
// rtl/register_file.sv - 32x32 2R1W register file, $0 hardwired, async active-low clear
// DECODE_RF_BYPASS_EN: same-cycle write-through from the write port to matching read ports.
module register_file (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_we,
  input  logic [4:0]  i_waddr,
  input  logic [31:0] i_wdata,
  input  logic [4:0]  i_raddr1,
  input  logic [4:0]  i_raddr2,
  output logic [31:0] o_rdata1,
  output logic [31:0] o_rdata2
);

  logic [31:0] r_mem [32];
  logic [31:0] w_stored1;
  logic [31:0] w_stored2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) r_mem[i] <= '0;
    end else if (i_we && (i_waddr != 5'd0)) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign w_stored1 = (i_raddr1 == 5'd0) ? 32'd0 : r_mem[i_raddr1];
  assign w_stored2 = (i_raddr2 == 5'd0) ? 32'd0 : r_mem[i_raddr2];

`ifdef DECODE_RF_BYPASS_EN
  assign o_rdata1 = (i_we && (i_waddr != 5'd0) && (i_waddr == i_raddr1)) ? i_wdata : w_stored1;
  assign o_rdata2 = (i_we && (i_waddr != 5'd0) && (i_waddr == i_raddr2)) ? i_wdata : w_stored2;
`else
  assign o_rdata1 = w_stored1;
  assign o_rdata2 = w_stored2;
`endif

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - MIPS ID stage: control decode, register read, sign-extend, ID/EX register
// DECODE_RF_BYPASS_EN selects write-through reads in the register file.
module decode_stage
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] InstrDe,
  input  logic [31:0] PCDe,
  input  logic [31:0] PCplus4De,
  input  logic        RegWriteW,
  input  logic [4:0]  RDW,
  input  logic [31:0] ResultW,
  input  logic        FlushEx,
  output logic        RegWriteEx,
  output logic        MemtoRegEx,
  output logic        MemWriteEx,
  output logic        BranchEx,
  output logic        ALUSrcEx,
  output logic        RegDstEx,
  output logic [2:0]  ALUControlEx,
  output logic [31:0] RD1Ex,
  output logic [31:0] RD2Ex,
  output logic [31:0] ImmExtEx,
  output logic [4:0]  RsEx,
  output logic [4:0]  RtEx,
  output logic [4:0]  RdEx,
  output logic [31:0] PCEx,
  output logic [31:0] PCplus4Ex
);

  ctrl_t       w_ctrl;
  logic [31:0] w_rd1;
  logic [31:0] w_rd2;
  logic [31:0] w_imm_ext;

  ctrl_t       r_ctrl;
  logic [31:0] r_rd1;
  logic [31:0] r_rd2;
  logic [31:0] r_imm_ext;
  logic [4:0]  r_rs;
  logic [4:0]  r_rt;
  logic [4:0]  r_rd;
  logic [31:0] r_pc;
  logic [31:0] r_pc_plus4;

  assign w_ctrl    = decode_ctrl(InstrDe[31:26], InstrDe[5:0]);
  assign w_imm_ext = {{16{InstrDe[15]}}, InstrDe[15:0]};

  register_file u_register_file (
    .clk      (clk),
    .rst_n    (rst),
    .i_we     (RegWriteW),
    .i_waddr  (RDW),
    .i_wdata  (ResultW),
    .i_raddr1 (InstrDe[25:21]),
    .i_raddr2 (InstrDe[20:16]),
    .o_rdata1 (w_rd1),
    .o_rdata2 (w_rd2)
  );

  // A flush replaces the whole ID/EX payload with zeros so execute sees a bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst || FlushEx) begin
      r_ctrl     <= '0;
      r_rd1      <= '0;
      r_rd2      <= '0;
      r_imm_ext  <= '0;
      r_rs       <= '0;
      r_rt       <= '0;
      r_rd       <= '0;
      r_pc       <= '0;
      r_pc_plus4 <= '0;
    end else begin
      r_ctrl     <= w_ctrl;
      r_rd1      <= w_rd1;
      r_rd2      <= w_rd2;
      r_imm_ext  <= w_imm_ext;
      r_rs       <= InstrDe[25:21];
      r_rt       <= InstrDe[20:16];
      r_rd       <= InstrDe[15:11];
      r_pc       <= PCDe;
      r_pc_plus4 <= PCplus4De;
    end
  end

  assign RegWriteEx   = rst & r_ctrl.reg_write;
  assign MemtoRegEx   = rst & r_ctrl.mem_to_reg;
  assign MemWriteEx   = rst & r_ctrl.mem_write;
  assign BranchEx     = rst & r_ctrl.branch;
  assign ALUSrcEx     = rst & r_ctrl.alu_src;
  assign RegDstEx     = rst & r_ctrl.reg_dst;
  assign ALUControlEx = rst ? r_ctrl.alu_control : 3'd0;
  assign RD1Ex        = rst ? r_rd1      : 32'd0;
  assign RD2Ex        = rst ? r_rd2      : 32'd0;
  assign ImmExtEx     = rst ? r_imm_ext  : 32'd0;
  assign RsEx         = rst ? r_rs       : 5'd0;
  assign RtEx         = rst ? r_rt       : 5'd0;
  assign RdEx         = rst ? r_rd       : 5'd0;
  assign PCEx         = rst ? r_pc       : 32'd0;
  assign PCplus4Ex    = rst ? r_pc_plus4 : 32'd0;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - self-checking bench for decode_stage against a behavioural model
// DECODE_RF_BYPASS_EN selects the expected same-cycle read behaviour.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] InstrDe;
  logic [31:0] PCDe;
  logic [31:0] PCplus4De;
  logic        RegWriteW;
  logic [4:0]  RDW;
  logic [31:0] ResultW;
  logic        FlushEx;
  logic        RegWriteEx, MemtoRegEx, MemWriteEx, BranchEx, ALUSrcEx, RegDstEx;
  logic [2:0]  ALUControlEx;
  logic [31:0] RD1Ex, RD2Ex, ImmExtEx, PCEx, PCplus4Ex;
  logic [4:0]  RsEx, RtEx, RdEx;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  logic [31:0]  mregs [32];
  logic [183:0] exp_v;
  wire  [183:0] obs_v = {RegWriteEx, MemtoRegEx, MemWriteEx, BranchEx, ALUSrcEx, RegDstEx,
                         ALUControlEx, RD1Ex, RD2Ex, ImmExtEx, RsEx, RtEx, RdEx, PCEx, PCplus4Ex};

  decode_stage dut (
    .clk(clk), .rst(rst), .InstrDe(InstrDe), .PCDe(PCDe), .PCplus4De(PCplus4De),
    .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW), .FlushEx(FlushEx),
    .RegWriteEx(RegWriteEx), .MemtoRegEx(MemtoRegEx), .MemWriteEx(MemWriteEx),
    .BranchEx(BranchEx), .ALUSrcEx(ALUSrcEx), .RegDstEx(RegDstEx),
    .ALUControlEx(ALUControlEx), .RD1Ex(RD1Ex), .RD2Ex(RD2Ex), .ImmExtEx(ImmExtEx),
    .RsEx(RsEx), .RtEx(RtEx), .RdEx(RdEx), .PCEx(PCEx), .PCplus4Ex(PCplus4Ex)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] read_reg(input logic [4:0] a, input logic we,
                                           input logic [4:0] wa, input logic [31:0] wd);
    if (a == 5'd0) return 32'd0;
`ifdef DECODE_RF_BYPASS_EN
    if (we && wa == a) return wd;
`endif
    return mregs[a];
  endfunction

  function automatic logic [183:0] model(input logic [31:0] ins, input logic [31:0] pc,
                                         input logic we, input logic [4:0] wa,
                                         input logic [31:0] wd, input logic fl);
    logic rw, mr, mw, br, as, rdst;
    logic [2:0] alu;
    {rw, mr, mw, br, as, rdst} = 6'b0;
    alu = 3'b000;
    if (fl) return '0;
    case (ins[31:26])
      6'd0: begin
        rdst = 1'b1;
        rw   = 1'b1;
        case (ins[5:0])
          6'h20: alu = 3'b010;
          6'h22: alu = 3'b110;
          6'h24: alu = 3'b000;
          6'h25: alu = 3'b001;
          6'h2a: alu = 3'b111;
          default: begin alu = 3'b010; rw = 1'b0; end
        endcase
      end
      6'h23: begin rw = 1'b1; as = 1'b1; mr = 1'b1; alu = 3'b010; end
      6'h2b: begin mw = 1'b1; as = 1'b1; alu = 3'b010; end
      6'h04: begin br = 1'b1; alu = 3'b110; end
      6'h08: begin rw = 1'b1; as = 1'b1; alu = 3'b010; end
      default: ;
    endcase
    return {rw, mr, mw, br, as, rdst, alu,
            read_reg(ins[25:21], we, wa, wd), read_reg(ins[20:16], we, wa, wd),
            {{16{ins[15]}}, ins[15:0]}, ins[25:21], ins[20:16], ins[15:11], pc, pc + 32'd4};
  endfunction

  task automatic chk(input string tag, input logic [183:0] o, input logic [183:0] e);
    checks++;
    assert (o === e) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic step(input string tag, input logic [31:0] ins, input logic we,
                      input logic [4:0] wa, input logic [31:0] wd, input logic fl);
    logic [31:0] pc;
    pc = $urandom & 32'hFFFF_FFFC;
    InstrDe = ins; PCDe = pc; PCplus4De = pc + 32'd4;
    RegWriteW = we; RDW = wa; ResultW = wd; FlushEx = fl;
    exp_v = model(ins, pc, we, wa, wd, fl);
    @(posedge clk);
    #1;
    if (we && wa != 5'd0) mregs[wa] = wd;
    chk(tag, obs_v, exp_v);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    logic [5:0] ops [6];
    logic [5:0] fns [6];
    ops = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h08, 6'h00};
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h00};
    ins = $urandom;
    ops[5] = 6'($urandom);
    fns[5] = 6'($urandom);
    ins[31:26] = ops[$urandom_range(0, 5)];
    if (ins[31:26] == 6'h00) ins[5:0] = fns[$urandom_range(0, 5)];
    return ins;
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    rst = 1'b0;
    InstrDe = 32'h8C22_0004; PCDe = 32'h100; PCplus4De = 32'h104;
    RegWriteW = 1'b0; RDW = 5'd0; ResultW = 32'd0; FlushEx = 1'b0;
    #1;
    chk("reset_outputs_zero", obs_v, '0);
    @(posedge clk); @(posedge clk); #1;
    chk("reset_held_over_edges", obs_v, '0);
    rst = 1'b1;

    step("lw_after_reset", 32'h8C22_0004, 1'b0, 5'd0, 32'd0, 1'b0);
    chk("lw_memtoreg", 184'(MemtoRegEx), 184'(1'b1));
    chk("lw_alusrc",   184'(ALUSrcEx),   184'(1'b1));
    chk("lw_imm",      184'(ImmExtEx),   184'(32'h4));
    chk("lw_rt",       184'(RtEx),       184'(5'd2));

    step("write_r5", 32'h0000_0000, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0);
    step("add_r3_r5_r0", 32'h00A0_1820, 1'b0, 5'd0, 32'd0, 1'b0);
    chk("add_rd1",    184'(RD1Ex),        184'(32'hDEAD_BEEF));
    chk("add_rd2",    184'(RD2Ex),        184'(32'd0));
    chk("add_alu",    184'(ALUControlEx), 184'(3'b010));
    chk("add_rd",     184'(RdEx),         184'(5'd3));
    chk("add_regdst", 184'(RegDstEx),     184'(1'b1));

    step("write_r0", 32'h0000_0020, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0);
    step("read_r0", 32'h0000_0020, 1'b0, 5'd0, 32'd0, 1'b0);
    chk("r0_stays_zero", 184'(RD1Ex), 184'(32'd0));

    step("beq_signext", 32'h1022_FFFF, 1'b0, 5'd0, 32'd0, 1'b0);
    chk("beq_imm",    184'(ImmExtEx),     184'(32'hFFFF_FFFF));
    chk("beq_branch", 184'(BranchEx),     184'(1'b1));
    chk("beq_alu",    184'(ALUControlEx), 184'(3'b110));

    step("flush_addi", 32'h20E7_0005, 1'b1, 5'd7, 32'hCAFE_0007, 1'b1);
    chk("flush_all_zero", obs_v, '0);
    step("read_r7_after_flush", 32'h00E0_0020, 1'b0, 5'd0, 32'd0, 1'b0);
    chk("flush_wb_commit", 184'(RD1Ex), 184'(32'hCAFE_0007));

    step("preload_r9", 32'h0000_0000, 1'b1, 5'd9, 32'h1111_1111, 1'b0);
    step("bypass_r9", 32'h0120_0020, 1'b1, 5'd9, 32'h1234_5678, 1'b0);
`ifdef DECODE_RF_BYPASS_EN
    chk("bypass_rd1", 184'(RD1Ex), 184'(32'h1234_5678));
`else
    chk("bypass_rd1", 184'(RD1Ex), 184'(32'h1111_1111));
`endif
    step("r9_next_cycle", 32'h0120_0020, 1'b0, 5'd0, 32'd0, 1'b0);
    chk("r9_new_value", 184'(RD1Ex), 184'(32'h1234_5678));

    for (int n = 0; n < 300; n++) begin
      logic [31:0] ins;
      logic [4:0]  wa;
      ins = rand_instr();
      wa  = ($urandom_range(0, 2) == 0) ? ins[25:21] : 5'($urandom);
      step("random", ins, 1'($urandom), wa, $urandom, ($urandom_range(0, 7) == 0));
    end

    rst = 1'b0;
    #1;
    chk("async_reset_outputs", obs_v, '0);
    for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    @(negedge clk);
    rst = 1'b1;
    step("read_r5_after_reset", 32'h00A0_1820, 1'b0, 5'd0, 32'd0, 1'b0);
    chk("rf_cleared_by_reset", 184'(RD1Ex), 184'(32'd0));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
